aes_kat_sequencer: RTL and testbench

AES_KAT_SEQUENCER -- requirements
Module: aes_kat_sequencer

---
 rtl/aes_kat_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: walks an external ROM of AES known-answer vectors,
// drives a cipher core and an inverse-cipher core for each vector, checks the
// ciphertext and the round-trip plaintext, and tallies passing/failing vectors.
`timescale 1ns/1ps
module aes_kat_sequencer #(
    parameter int NK      = 4,
    parameter int NV      = 4,
    parameter int TIMEOUT = 64,
    parameter int LOOP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [3:0]        vec_idx,
    input  logic [127:0]      vec_plain,
    input  logic [32*NK-1:0]  vec_key,
    input  logic [127:0]      vec_cipher,
    output logic [32*NK-1:0]  key_out,
    output logic              enc_start,
    output logic [127:0]      enc_in,
    input  logic              enc_done,
    input  logic [127:0]      enc_out,
    output logic              dec_start,
    output logic [127:0]      dec_in,
    input  logic              dec_done,
    input  logic [127:0]      dec_out,
    output logic              busy,
    output logic              run_done,
    output logic              vec_pass,
    output logic [4:0]        pass_cnt,
    output logic [4:0]        fail_cnt,
    output logic [4:0]        first_fail,
    output logic [7:0]        disp_byte
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ENC_REQ,
        ENC_WAIT,
        DEC_REQ,
        DEC_WAIT,
        NEXT,
        DONE
    } stateT;

    localparam logic [3:0] LAST_IDX = 4'(NV - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [4:0] CNT_MAX  = 5'd31;

    stateT state, nextState;

    logic [127:0]     expReg, expNext;
    logic [7:0]       toCnt, toCntNext;
    logic             encOk, encOkNext;
    logic             decOk, decOkNext;
    logic             timedOut, timedOutNext;
    logic [7:0]       lastDec, lastDecNext;

    logic [3:0]       vecIdxNext;
    logic [32*NK-1:0] keyNext;
    logic [127:0]     encInNext;
    logic [127:0]     decInNext;
    logic [4:0]       passNext;
    logic [4:0]       failNext;
    logic [4:0]       firstNext;
    logic             encStartNext;
    logic             decStartNext;
    logic             busyNext;
    logic             runDoneNext;
    logic             vecPassNext;
    logic [7:0]       dispNext;

    logic             timeoutHit;
    logic             vecGood;

    // The last permitted wait cycle; a done arriving in this cycle still wins.
    assign timeoutHit = (toCnt == TO_LAST);
    assign vecGood    = encOk & decOk & ~timedOut;

    // State register; reset returns to IDLE without waiting for the cores.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; done pulses only matter in the matching WAIT state.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (start) nextState = LOAD;
            LOAD:     nextState = ENC_REQ;
            ENC_REQ:  nextState = ENC_WAIT;
            ENC_WAIT: begin
                if (enc_done) begin
                    nextState = DEC_REQ;
                end else if (timeoutHit) begin
                    nextState = NEXT;
                end
            end
            DEC_REQ:  nextState = DEC_WAIT;
            DEC_WAIT: if (dec_done || timeoutHit) nextState = NEXT;
            NEXT:     nextState = (vec_idx == LAST_IDX) ? DONE : LOAD;
            DONE:     if ((LOOP != 0) || start) nextState = LOAD;
            default:  nextState = IDLE;
        endcase
    end

    // Next values for the datapath and every output register; strobes and
    // status flags are derived from nextState so they line up with the state.
    always_comb begin
        vecIdxNext   = vec_idx;
        keyNext      = key_out;
        encInNext    = enc_in;
        decInNext    = dec_in;
        expNext      = expReg;
        encOkNext    = encOk;
        decOkNext    = decOk;
        timedOutNext = timedOut;
        toCntNext    = toCnt;
        lastDecNext  = lastDec;
        passNext     = pass_cnt;
        failNext     = fail_cnt;
        firstNext    = first_fail;
        vecPassNext  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    vecIdxNext = 4'd0;
                    passNext   = 5'd0;
                    failNext   = 5'd0;
                    firstNext  = 5'd0;
                end
            end
            LOAD: begin
                keyNext      = vec_key;
                encInNext    = vec_plain;
                expNext      = vec_cipher;
                encOkNext    = 1'b0;
                decOkNext    = 1'b0;
                timedOutNext = 1'b0;
            end
            ENC_REQ, DEC_REQ: begin
                toCntNext = 8'd0;
            end
            ENC_WAIT: begin
                if (enc_done) begin
                    decInNext = enc_out;
                    encOkNext = (enc_out == expReg);
                end else if (timeoutHit) begin
                    timedOutNext = 1'b1;
                end else begin
                    toCntNext = toCnt + 8'd1;
                end
            end
            DEC_WAIT: begin
                if (dec_done) begin
                    decOkNext   = (dec_out == enc_in);
                    lastDecNext = dec_out[7:0];
                end else if (timeoutHit) begin
                    timedOutNext = 1'b1;
                end else begin
                    toCntNext = toCnt + 8'd1;
                end
            end
            NEXT: begin
                if (vecGood) begin
                    if (pass_cnt != CNT_MAX) passNext = pass_cnt + 5'd1;
                    vecPassNext = 1'b1;
                end else begin
                    if (fail_cnt != CNT_MAX) failNext = fail_cnt + 5'd1;
                    if (!first_fail[4]) firstNext = {1'b1, vec_idx};
                end
                if (vec_idx != LAST_IDX) vecIdxNext = vec_idx + 4'd1;
            end
            DONE: begin
                if (nextState == LOAD) begin
                    vecIdxNext = 4'd0;
                    passNext   = 5'd0;
                    failNext   = 5'd0;
                    firstNext  = 5'd0;
                end
            end
            default: ;
        endcase

        encStartNext = (nextState == ENC_REQ);
        decStartNext = (nextState == DEC_REQ);
        busyNext     = !((nextState == IDLE) || (nextState == DONE));
        runDoneNext  = (nextState == DONE);

        case (nextState)
            LOAD, ENC_REQ, ENC_WAIT: dispNext = encInNext[7:0];
            DEC_REQ, DEC_WAIT:       dispNext = decInNext[7:0];
            NEXT, DONE:              dispNext = lastDecNext;
            default:                 dispNext = 8'd0;
        endcase
    end

    // Datapath and output registers; everything visible outside is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_idx    <= 4'd0;
            key_out    <= '0;
            enc_in     <= 128'd0;
            dec_in     <= 128'd0;
            expReg     <= 128'd0;
            encOk      <= 1'b0;
            decOk      <= 1'b0;
            timedOut   <= 1'b0;
            toCnt      <= 8'd0;
            lastDec    <= 8'd0;
            pass_cnt   <= 5'd0;
            fail_cnt   <= 5'd0;
            first_fail <= 5'd0;
            enc_start  <= 1'b0;
            dec_start  <= 1'b0;
            busy       <= 1'b0;
            run_done   <= 1'b0;
            vec_pass   <= 1'b0;
            disp_byte  <= 8'd0;
        end else begin
            vec_idx    <= vecIdxNext;
            key_out    <= keyNext;
            enc_in     <= encInNext;
            dec_in     <= decInNext;
            expReg     <= expNext;
            encOk      <= encOkNext;
            decOk      <= decOkNext;
            timedOut   <= timedOutNext;
            toCnt      <= toCntNext;
            lastDec    <= lastDecNext;
            pass_cnt   <= passNext;
            fail_cnt   <= failNext;
            first_fail <= firstNext;
            enc_start  <= encStartNext;
            dec_start  <= decStartNext;
            busy       <= busyNext;
            run_done   <= runDoneNext;
            vec_pass   <= vecPassNext;
            disp_byte  <= dispNext;
        end
    end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Testbench for aes_kat_sequencer: three instances (AES-128 single vector,
// AES-256 single vector with short timeout, AES-128 four vectors looping)
// each paired with behavioural cipher/inverse-cipher core stand-ins.
`timescale 1ns/1ps
module tb_aes_kat_sequencer;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int LAT_A = 11;
    localparam int LAT_BC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int collisions = 0;

    // ---------------- instance A: NK=4, NV=1 ----------------
    logic aReset = 1'b1, aStart = 1'b0;
    logic [3:0] aVecIdx;
    logic [127:0] aKeyOut, aEncIn, aDecIn;
    logic [127:0] aEncOut = '0, aDecOut = '0;
    logic aEncDone = 1'b0, aDecDone = 1'b0;
    logic aEncStart, aDecStart, aBusy, aRunDone, aVecPass;
    logic [4:0] aPassCnt, aFailCnt, aFirstFail;
    logic [7:0] aDisp;
    int aEncCnt = 0, aDecCnt = 0;

    aes_kat_sequencer #(.NK(4), .NV(1), .TIMEOUT(64), .LOOP(0)) dutA (
        .clk(clk), .reset(aReset), .start(aStart), .vec_idx(aVecIdx),
        .vec_plain(PT), .vec_key(K128), .vec_cipher(C1), .key_out(aKeyOut),
        .enc_start(aEncStart), .enc_in(aEncIn), .enc_done(aEncDone), .enc_out(aEncOut),
        .dec_start(aDecStart), .dec_in(aDecIn), .dec_done(aDecDone), .dec_out(aDecOut),
        .busy(aBusy), .run_done(aRunDone), .vec_pass(aVecPass), .pass_cnt(aPassCnt),
        .fail_cnt(aFailCnt), .first_fail(aFirstFail), .disp_byte(aDisp)
    );

    // Core stand-ins for A: fixed latency, recognise the FIPS-197 C.1 pair
    always @(posedge clk) begin
        aEncDone <= 1'b0;
        aDecDone <= 1'b0;
        if (aEncStart) aEncCnt <= LAT_A;
        else if (aEncCnt > 0) begin
            aEncCnt <= aEncCnt - 1;
            if (aEncCnt == 1) begin
                aEncDone <= 1'b1;
                aEncOut  <= (aEncIn == PT && aKeyOut == K128) ? C1 : ~aEncIn;
            end
        end
        if (aDecStart) aDecCnt <= LAT_A;
        else if (aDecCnt > 0) begin
            aDecCnt <= aDecCnt - 1;
            if (aDecCnt == 1) begin
                aDecDone <= 1'b1;
                aDecOut  <= (aDecIn == C1 && aKeyOut == K128) ? PT : ~aDecIn;
            end
        end
    end

    // ---------------- instance B: NK=8, NV=1, TIMEOUT=8 ----------------
    logic bReset = 1'b1, bStart = 1'b0, bBad = 1'b0;
    logic [3:0] bVecIdx;
    logic [255:0] bKeyOut;
    logic [127:0] bEncIn, bDecIn, bVecCipher;
    logic [127:0] bEncOut = '0, bDecOut = '0;
    logic bEncDone = 1'b0, bDecDone = 1'b0;
    logic bEncStart, bDecStart, bBusy, bRunDone, bVecPass;
    logic [4:0] bPassCnt, bFailCnt, bFirstFail;
    logic [7:0] bDisp;
    int bEncCnt = 0, bDecCnt = 0;

    assign bVecCipher = (bBad && bVecIdx == 4'd0) ? (C3 ^ 128'h1) : C3;

    aes_kat_sequencer #(.NK(8), .NV(1), .TIMEOUT(8), .LOOP(0)) dutB (
        .clk(clk), .reset(bReset), .start(bStart), .vec_idx(bVecIdx),
        .vec_plain(PT), .vec_key(K256), .vec_cipher(bVecCipher), .key_out(bKeyOut),
        .enc_start(bEncStart), .enc_in(bEncIn), .enc_done(bEncDone), .enc_out(bEncOut),
        .dec_start(bDecStart), .dec_in(bDecIn), .dec_done(bDecDone), .dec_out(bDecOut),
        .busy(bBusy), .run_done(bRunDone), .vec_pass(bVecPass), .pass_cnt(bPassCnt),
        .fail_cnt(bFailCnt), .first_fail(bFirstFail), .disp_byte(bDisp)
    );

    // Core stand-ins for B: recognise the FIPS-197 C.3 pair
    always @(posedge clk) begin
        bEncDone <= 1'b0;
        bDecDone <= 1'b0;
        if (bEncStart) bEncCnt <= LAT_BC;
        else if (bEncCnt > 0) begin
            bEncCnt <= bEncCnt - 1;
            if (bEncCnt == 1) begin
                bEncDone <= 1'b1;
                bEncOut  <= (bEncIn == PT && bKeyOut == K256) ? C3 : ~bEncIn;
            end
        end
        if (bDecStart) bDecCnt <= LAT_BC;
        else if (bDecCnt > 0) begin
            bDecCnt <= bDecCnt - 1;
            if (bDecCnt == 1) begin
                bDecDone <= 1'b1;
                bDecOut  <= (bDecIn == C3 && bKeyOut == K256) ? PT : ~bDecIn;
            end
        end
    end

    // ---------------- instance C: NK=4, NV=4, TIMEOUT=8, LOOP=1 ----------------
    logic cReset = 1'b1, cStart = 1'b0, cKill = 1'b0, cBad2 = 1'b0;
    logic [3:0] cVecIdx;
    logic [127:0] cKeyOut, cEncIn, cDecIn, cVecCipher;
    logic [127:0] cEncOut = '0, cDecOut = '0;
    logic cEncDone = 1'b0, cDecDone = 1'b0, cEncMute = 1'b0;
    logic cEncStart, cDecStart, cBusy, cRunDone, cVecPass;
    logic [4:0] cPassCnt, cFailCnt, cFirstFail;
    logic [7:0] cDisp;
    int cEncCnt = 0, cDecCnt = 0;

    assign cVecCipher = (cBad2 && cVecIdx == 4'd2) ? (C1 ^ 128'h1) : C1;

    aes_kat_sequencer #(.NK(4), .NV(4), .TIMEOUT(8), .LOOP(1)) dutC (
        .clk(clk), .reset(cReset), .start(cStart), .vec_idx(cVecIdx),
        .vec_plain(PT), .vec_key(K128), .vec_cipher(cVecCipher), .key_out(cKeyOut),
        .enc_start(cEncStart), .enc_in(cEncIn), .enc_done(cEncDone), .enc_out(cEncOut),
        .dec_start(cDecStart), .dec_in(cDecIn), .dec_done(cDecDone), .dec_out(cDecOut),
        .busy(cBusy), .run_done(cRunDone), .vec_pass(cVecPass), .pass_cnt(cPassCnt),
        .fail_cnt(cFailCnt), .first_fail(cFirstFail), .disp_byte(cDisp)
    );

    // Core stand-ins for C: the cipher core stays silent for vector 1 while cKill is set
    always @(posedge clk) begin
        cEncDone <= 1'b0;
        cDecDone <= 1'b0;
        if (cEncStart) begin
            cEncCnt  <= LAT_BC;
            cEncMute <= cKill && (cVecIdx == 4'd1);
        end else if (cEncCnt > 0) begin
            cEncCnt <= cEncCnt - 1;
            if (cEncCnt == 1 && !cEncMute) begin
                cEncDone <= 1'b1;
                cEncOut  <= (cEncIn == PT && cKeyOut == K128) ? C1 : ~cEncIn;
            end
        end
        if (cDecStart) cDecCnt <= LAT_BC;
        else if (cDecCnt > 0) begin
            cDecCnt <= cDecCnt - 1;
            if (cDecCnt == 1) begin
                cDecDone <= 1'b1;
                cDecOut  <= (cDecIn == C1 && cKeyOut == K128) ? PT : ~cDecIn;
            end
        end
    end

    // Watch for both core starts high together on any instance
    always @(posedge clk) begin
        if ((aEncStart && aDecStart) || (bEncStart && bDecStart) || (cEncStart && cDecStart))
            collisions <= collisions + 1;
    end

    // Pulse start on A and wait for run_done, counting vec_pass pulses
    task automatic runA(output int vp, output bit ok);
        vp = 0; ok = 1'b0;
        aStart = 1'b1; @(negedge clk); aStart = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (aVecPass) vp++;
            if (aRunDone) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic runB(output int vp, output bit ok);
        vp = 0; ok = 1'b0;
        bStart = 1'b1; @(negedge clk); bStart = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (bVecPass) vp++;
            if (bRunDone) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    // Follow C from the current negedge to run_done, recording events
    task automatic runC(output int vp, output int decs, output int tEnc, output int tFail, output bit ok);
        vp = 0; decs = 0; tEnc = -1; tFail = -1; ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (cVecPass) vp++;
            if (cDecStart) decs++;
            if (cEncStart && cVecIdx == 4'd1 && tEnc < 0) tEnc = t;
            if (cFailCnt != 5'd0 && tFail < 0) tFail = t;
            if (cRunDone) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        aReset = 1'b1; bReset = 1'b1; cReset = 1'b1;
        repeat (2) @(negedge clk);
        aReset = 1'b0; bReset = 1'b0; cReset = 1'b0;
        @(negedge clk);
        checks++; if ({aEncStart, aDecStart, aVecPass, aBusy, aRunDone} !== 5'd0) $display("[TB] FAIL reset_strobes got %b want 00000", {aEncStart, aDecStart, aVecPass, aBusy, aRunDone}); else passes++;
        checks++; if (aVecIdx !== 4'd0) $display("[TB] FAIL reset_vec_idx got %0d want 0", aVecIdx); else passes++;
        checks++; if ({aPassCnt, aFailCnt, aFirstFail} !== 15'd0) $display("[TB] FAIL reset_counts got %h want 0", {aPassCnt, aFailCnt, aFirstFail}); else passes++;
        checks++; if ({aKeyOut, aEncIn, aDecIn} !== 384'd0) $display("[TB] FAIL reset_data got nonzero want 0"); else passes++;
        checks++; if (aDisp !== 8'h00) $display("[TB] FAIL reset_disp got %h want 00", aDisp); else passes++;
    endtask

    task automatic test_kat128();
        int vp; bit ok;
        runA(vp, ok);
        checks++; if (!ok) $display("[TB] FAIL kat128_run_done got timeout want done"); else passes++;
        checks++; if (aPassCnt !== 5'd1) $display("[TB] FAIL kat128_pass_cnt got %0d want 1", aPassCnt); else passes++;
        checks++; if (aFailCnt !== 5'd0) $display("[TB] FAIL kat128_fail_cnt got %0d want 0", aFailCnt); else passes++;
        checks++; if (aFirstFail !== 5'd0) $display("[TB] FAIL kat128_first_fail got %b want 00000", aFirstFail); else passes++;
        checks++; if (aDecIn !== C1) $display("[TB] FAIL kat128_enc_result got %h want %h", aDecIn, C1); else passes++;
        checks++; if (aKeyOut !== K128) $display("[TB] FAIL kat128_key_out got %h want %h", aKeyOut, K128); else passes++;
        checks++; if (aDisp !== 8'hff) $display("[TB] FAIL kat128_disp got %h want ff", aDisp); else passes++;
        checks++; if (vp !== 1) $display("[TB] FAIL kat128_vec_pass got %0d want 1", vp); else passes++;
        checks++; if (aBusy !== 1'b0) $display("[TB] FAIL kat128_busy got %b want 0", aBusy); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (aRunDone !== 1'b1) $display("[TB] FAIL kat128_done_hold got %b want 1", aRunDone); else passes++;
    endtask

    task automatic test_reset_mid();
        int vp, busySeen; bit seen, ok;
        seen = 1'b0; vp = 0; busySeen = 0;
        aStart = 1'b1; @(negedge clk); aStart = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (aDecStart) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) $display("[TB] FAIL midreset_dec_start got none want pulse"); else passes++;
        repeat (2) @(negedge clk);
        aReset = 1'b1; @(negedge clk); aReset = 1'b0;
        checks++; if ({aBusy, aRunDone} !== 2'b00) $display("[TB] FAIL midreset_state got %b want 00", {aBusy, aRunDone}); else passes++;
        checks++; if ({aVecIdx, aPassCnt, aFailCnt, aFirstFail} !== 19'd0) $display("[TB] FAIL midreset_counts got %h want 0", {aVecIdx, aPassCnt, aFailCnt, aFirstFail}); else passes++;
        checks++; if ({aDecIn, aDisp} !== 136'd0) $display("[TB] FAIL midreset_data got nonzero want 0"); else passes++;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (aVecPass) vp++;
            if (aBusy) busySeen++;
        end
        checks++; if (vp !== 0 || busySeen !== 0) $display("[TB] FAIL late_done_ignored got vp=%0d busy=%0d want 0 0", vp, busySeen); else passes++;
        checks++; if (aPassCnt !== 5'd0) $display("[TB] FAIL late_done_pass_cnt got %0d want 0", aPassCnt); else passes++;
        runA(vp, ok);
        checks++; if (!ok || aPassCnt !== 5'd1 || aFailCnt !== 5'd0 || vp !== 1) $display("[TB] FAIL rerun_after_reset got ok=%0d pass=%0d fail=%0d vp=%0d want 1 1 0 1", ok, aPassCnt, aFailCnt, vp); else passes++;
    endtask

    task automatic test_kat256();
        int vp; bit ok;
        bBad = 1'b0;
        runB(vp, ok);
        checks++; if (!ok) $display("[TB] FAIL kat256_run_done got timeout want done"); else passes++;
        checks++; if (bPassCnt !== 5'd1 || bFailCnt !== 5'd0) $display("[TB] FAIL kat256_counts got pass=%0d fail=%0d want 1 0", bPassCnt, bFailCnt); else passes++;
        checks++; if (bDecIn !== C3) $display("[TB] FAIL kat256_enc_result got %h want %h", bDecIn, C3); else passes++;
        checks++; if (bKeyOut !== K256) $display("[TB] FAIL kat256_key_out got %h want %h", bKeyOut, K256); else passes++;
        checks++; if (vp !== 1) $display("[TB] FAIL kat256_vec_pass got %0d want 1", vp); else passes++;
    endtask

    task automatic test_corrupt();
        int vp; bit ok;
        bBad = 1'b1;
        runB(vp, ok);
        checks++; if (!ok) $display("[TB] FAIL corrupt_run_done got timeout want done"); else passes++;
        checks++; if (bPassCnt !== 5'd0 || bFailCnt !== 5'd1) $display("[TB] FAIL corrupt_counts got pass=%0d fail=%0d want 0 1", bPassCnt, bFailCnt); else passes++;
        checks++; if (bFirstFail !== 5'b10000) $display("[TB] FAIL corrupt_first_fail got %b want 10000", bFirstFail); else passes++;
        checks++; if (bDecIn !== C3 || bDisp !== 8'hff) $display("[TB] FAIL corrupt_decrypt_ran got dec_in=%h disp=%h want %h ff", bDecIn, bDisp, C3); else passes++;
        checks++; if (vp !== 0 || bBusy !== 1'b0) $display("[TB] FAIL corrupt_no_pass got vp=%0d busy=%b want 0 0", vp, bBusy); else passes++;
        bBad = 1'b0;
    endtask

    task automatic test_timeout_loop();
        int vp, decs, tEnc, tFail; bit ok;
        cKill = 1'b1; cBad2 = 1'b0;
        cStart = 1'b1; @(negedge clk); cStart = 1'b0;
        runC(vp, decs, tEnc, tFail, ok);
        checks++; if (!ok) $display("[TB] FAIL timeout_run_done got timeout want done"); else passes++;
        checks++; if (tEnc < 0 || tFail - tEnc !== 10) $display("[TB] FAIL timeout_latency got %0d want 10", tFail - tEnc); else passes++;
        checks++; if (decs !== 3) $display("[TB] FAIL timeout_dec_starts got %0d want 3", decs); else passes++;
        checks++; if (cPassCnt !== 5'd3 || cFailCnt !== 5'd1 || cFirstFail !== 5'b10001) $display("[TB] FAIL timeout_counts got pass=%0d fail=%0d ff=%b want 3 1 10001", cPassCnt, cFailCnt, cFirstFail); else passes++;
        checks++; if (vp !== 3) $display("[TB] FAIL timeout_vec_pass got %0d want 3", vp); else passes++;
        cKill = 1'b0; cBad2 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            checks++; if ({cPassCnt, cFailCnt, cFirstFail, cVecIdx} !== 19'd0 || cBusy !== 1'b1) $display("[TB] FAIL loop_restart_clear got %h busy=%b want 0 1", {cPassCnt, cFailCnt, cFirstFail, cVecIdx}, cBusy); else passes++;
            runC(vp, decs, tEnc, tFail, ok);
            checks++; if (!ok || cPassCnt !== 5'd3 || cFailCnt !== 5'd1 || cFirstFail !== 5'b10010) $display("[TB] FAIL loop_run_counts got ok=%0d pass=%0d fail=%0d ff=%b want 1 3 1 10010", ok, cPassCnt, cFailCnt, cFirstFail); else passes++;
            checks++; if (decs !== 4 || vp !== 3) $display("[TB] FAIL loop_run_strobes got decs=%0d vp=%0d want 4 3", decs, vp); else passes++;
            checks++; if (cDisp !== 8'hff) $display("[TB] FAIL loop_disp got %h want ff", cDisp); else passes++;
        end
        cReset = 1'b1; @(negedge clk); cReset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_kat128();
        test_reset_mid();
        test_kat256();
        test_corrupt();
        test_timeout_loop();
        checks++; if (collisions !== 0) $display("[TB] FAIL start_collision got %0d want 0", collisions); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
